// File: rtl/free_list_if.sv
// Allocation, retire and flush-return signals between rename/ROB and the free pool.
interface free_list_if #(
  parameter int unsigned N_WAY    = 2,
  parameter int unsigned N_ROB    = 32,
  parameter int unsigned TAG_BITS = 6
);
  logic [N_WAY-1:0]                alloc_req;
  logic [N_WAY-1:0]                alloc_valid;
  logic [N_WAY-1:0][TAG_BITS-1:0]  alloc_tag;
  logic [TAG_BITS:0]               free_count;
  logic [N_WAY-1:0]                retire_valid;
  logic [N_WAY-1:0][TAG_BITS-1:0]  retire_told;
  logic                            branch_haz;
  logic [N_ROB-1:0][TAG_BITS-1:0]  free_list_haz;
  logic                            err_double_free;

  modport master (
    output alloc_req, retire_valid, retire_told, branch_haz, free_list_haz,
    input  alloc_valid, alloc_tag, free_count, err_double_free
  );

  modport slave (
    input  alloc_req, retire_valid, retire_told, branch_haz, free_list_haz,
    output alloc_valid, alloc_tag, free_count, err_double_free
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free pool: one free bit per PR, lowest-index-first allocation,
// returns from ROB retire lanes and from squashed instructions on a taken-branch flush.
module free_list #(
  parameter int unsigned N_WAY    = 2,
  parameter int unsigned N_ROB    = 32,
  parameter int unsigned N_PR     = 64,
  parameter int unsigned N_ARCH   = 32,
  parameter int unsigned TAG_BITS = $clog2(N_PR)
) (
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave fl
);

  localparam int unsigned CNT_W = TAG_BITS + 1;
  localparam int unsigned KW    = $clog2(N_WAY + 1);
  localparam logic [N_PR-1:0] RST_VEC = {N_PR{1'b1}} << N_ARCH;

  logic [N_PR-1:0]     free_vec;
  logic [CNT_W-1:0]    free_count;
  logic                err_double_free;

  logic [TAG_BITS-1:0] pick [N_WAY];
  logic [KW-1:0]       seen;
  logic [KW-1:0]       rank;
  logic [N_PR-1:0]     grant_mask;
  logic [N_PR-1:0]     ret_mask;
  logic [N_PR-1:0]     kept_vec;
  logic [N_PR-1:0]     free_vec_next;
  logic [CNT_W-1:0]    n_grant;
  logic [CNT_W-1:0]    n_new;
  logic [CNT_W-1:0]    free_count_next;
  logic                dbl_c;

  // First N_WAY free registers, lowest index first; PR 0 is never a candidate.
  always_comb begin
    seen = '0;
    for (int k = 0; k < N_WAY; k++) pick[k] = '0;
    for (int p = 1; p < N_PR; p++) begin
      if (free_vec[p]) begin
        for (int k = 0; k < N_WAY; k++) begin
          if (seen == KW'(k)) pick[k] = TAG_BITS'(p);
        end
        if (seen != KW'(N_WAY)) seen = seen + KW'(1);
      end
    end
  end

  // Lane i takes the rank-th candidate, rank = requests on lower lanes, so gaps are allowed.
  always_comb begin
    rank           = '0;
    fl.alloc_valid = '0;
    fl.alloc_tag   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (fl.alloc_req[i] && (CNT_W'(rank) < free_count) && !fl.branch_haz) begin
        fl.alloc_valid[i] = 1'b1;
        for (int k = 0; k < N_WAY; k++) begin
          if (rank == KW'(k)) fl.alloc_tag[i] = pick[k];
        end
      end
      if (fl.alloc_req[i]) rank = rank + KW'(1);
    end
  end

  // Grants clear first, returns set afterwards; a return of an already-free bit is a double free.
  always_comb begin
    grant_mask = '0;
    ret_mask   = '0;
    n_grant    = '0;
    n_new      = '0;
    dbl_c      = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (fl.alloc_valid[i]) begin
        grant_mask[fl.alloc_tag[i]] = 1'b1;
        n_grant = n_grant + CNT_W'(1);
      end
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (fl.retire_valid[i] && (fl.retire_told[i] != '0)) begin
        if (free_vec[fl.retire_told[i]] || ret_mask[fl.retire_told[i]]) dbl_c = 1'b1;
        ret_mask[fl.retire_told[i]] = 1'b1;
      end
    end
    if (fl.branch_haz) begin
      for (int j = 0; j < N_ROB; j++) begin
        if (fl.free_list_haz[j] != '0) begin
          if (free_vec[fl.free_list_haz[j]] || ret_mask[fl.free_list_haz[j]]) dbl_c = 1'b1;
          ret_mask[fl.free_list_haz[j]] = 1'b1;
        end
      end
    end
    kept_vec = free_vec & ~grant_mask;
    for (int p = 0; p < N_PR; p++) begin
      if (ret_mask[p] && !kept_vec[p]) n_new = n_new + CNT_W'(1);
    end
    free_vec_next   = kept_vec | ret_mask;
    free_count_next = free_count - n_grant + n_new;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_vec        <= RST_VEC;
      free_count      <= CNT_W'(N_PR - N_ARCH);
      err_double_free <= 1'b0;
    end else begin
      free_vec        <= free_vec_next;
      free_count      <= free_count_next;
      err_double_free <= err_double_free | dbl_c;
    end
  end

  assign fl.free_count      = free_count;
  assign fl.err_double_free = err_double_free;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation order, returns, drain, lane gaps, flush, double free.
module tb_free_list;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  free_list_if #(.N_WAY(2), .N_ROB(32), .TAG_BITS(6)) fl ();

  free_list #(.N_WAY(2), .N_ROB(32), .N_PR(64), .N_ARCH(32), .TAG_BITS(6)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // free_count must always match the number of set free bits.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (dut.free_vec[0] !== 1'b0 || 32'(fl.free_count) !== $countones(dut.free_vec)) begin
        errors++;
        $display("FAIL invariant t=%0t: free_count=%0d popcount=%0d bit0=%b",
                 $time, fl.free_count, $countones(dut.free_vec), dut.free_vec[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs;
    fl.alloc_req     = '0;
    fl.retire_valid  = '0;
    fl.retire_told   = '0;
    fl.branch_haz    = 1'b0;
    fl.free_list_haz = '0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (fl.free_count !== 7'd32) begin
      errors++; $display("FAIL reset_count: got %0d expected 32", fl.free_count);
    end
    checks++;
    if (fl.err_double_free !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", fl.err_double_free);
    end
    checks++;
    if (fl.alloc_valid !== 2'b00 || fl.alloc_tag !== 12'd0) begin
      errors++; $display("FAIL reset_idle: valid=%b tag=%h expected 00/000", fl.alloc_valid, fl.alloc_tag);
    end
  endtask

  task automatic test_alloc;
    fl.alloc_req = 2'b11;
    #1;
    checks++;
    if (fl.alloc_valid !== 2'b11 || fl.alloc_tag !== {6'd33, 6'd32}) begin
      errors++; $display("FAIL alloc_first: valid=%b tag=%h expected 11/%h", fl.alloc_valid, fl.alloc_tag, {6'd33, 6'd32});
    end
    tick();
    #1;
    checks++;
    if (fl.free_count !== 7'd30) begin
      errors++; $display("FAIL alloc_count: got %0d expected 30", fl.free_count);
    end
    checks++;
    if (fl.alloc_valid !== 2'b11 || fl.alloc_tag !== {6'd35, 6'd34}) begin
      errors++; $display("FAIL alloc_next: valid=%b tag=%h expected 11/%h", fl.alloc_valid, fl.alloc_tag, {6'd35, 6'd34});
    end
    fl.alloc_req = 2'b00;
  endtask

  task automatic test_retire;
    fl.retire_valid = 2'b11;
    fl.retire_told  = {6'd5, 6'd0};
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl.free_count !== 7'd31) begin
      errors++; $display("FAIL retire_count: got %0d expected 31", fl.free_count);
    end
    fl.alloc_req = 2'b01;
    #1;
    checks++;
    if (fl.alloc_valid !== 2'b01 || fl.alloc_tag !== {6'd0, 6'd5}) begin
      errors++; $display("FAIL retire_reuse: valid=%b tag=%h expected 01/%h", fl.alloc_valid, fl.alloc_tag, {6'd0, 6'd5});
    end
    fl.alloc_req = 2'b11;
    #1;
    checks++;
    if (fl.alloc_tag !== {6'd34, 6'd5}) begin
      errors++; $display("FAIL retire_tag0: tag=%h expected %h", fl.alloc_tag, {6'd34, 6'd5});
    end
    fl.alloc_req = 2'b00;
  endtask

  task automatic test_drain;
    fl.alloc_req = 2'b11;
    repeat (15) tick();
    #1;
    checks++;
    if (fl.free_count !== 7'd1) begin
      errors++; $display("FAIL drain_count: got %0d expected 1", fl.free_count);
    end
    checks++;
    if (fl.alloc_valid !== 2'b01 || fl.alloc_tag !== {6'd0, 6'd63}) begin
      errors++; $display("FAIL drain_last: valid=%b tag=%h expected 01/%h", fl.alloc_valid, fl.alloc_tag, {6'd0, 6'd63});
    end
    tick();
    #1;
    checks++;
    if (fl.free_count !== 7'd0) begin
      errors++; $display("FAIL drain_empty_count: got %0d expected 0", fl.free_count);
    end
    checks++;
    if (fl.alloc_valid !== 2'b00 || fl.alloc_tag !== 12'd0) begin
      errors++; $display("FAIL drain_empty_offer: valid=%b tag=%h expected 00/000", fl.alloc_valid, fl.alloc_tag);
    end
    fl.alloc_req = 2'b00;
  endtask

  task automatic test_lane_gap;
    fl.retire_valid = 2'b11;
    fl.retire_told  = {6'd20, 6'd10};
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl.free_count !== 7'd2) begin
      errors++; $display("FAIL gap_count: got %0d expected 2", fl.free_count);
    end
    fl.alloc_req = 2'b10;
    #1;
    checks++;
    if (fl.alloc_valid !== 2'b10 || fl.alloc_tag !== {6'd10, 6'd0}) begin
      errors++; $display("FAIL gap_lane1: valid=%b tag=%h expected 10/%h", fl.alloc_valid, fl.alloc_tag, {6'd10, 6'd0});
    end
    fl.alloc_req = 2'b01;
    #1;
    checks++;
    if (fl.alloc_valid !== 2'b01 || fl.alloc_tag !== {6'd0, 6'd10}) begin
      errors++; $display("FAIL gap_lane0: valid=%b tag=%h expected 01/%h", fl.alloc_valid, fl.alloc_tag, {6'd0, 6'd10});
    end
    fl.alloc_req = 2'b10;
    tick();
    fl.alloc_req = 2'b01;
    #1;
    checks++;
    if (fl.free_count !== 7'd1 || fl.alloc_tag !== {6'd0, 6'd20}) begin
      errors++; $display("FAIL gap_after: count=%0d tag=%h expected 1/%h", fl.free_count, fl.alloc_tag, {6'd0, 6'd20});
    end
    fl.alloc_req = 2'b00;
  endtask

  task automatic test_flush;
    fl.branch_haz       = 1'b1;
    fl.free_list_haz[0] = 6'd40;
    fl.free_list_haz[1] = 6'd41;
    fl.retire_valid     = 2'b01;
    fl.retire_told      = {6'd0, 6'd7};
    fl.alloc_req        = 2'b11;
    #1;
    checks++;
    if (fl.alloc_valid !== 2'b00 || fl.alloc_tag !== 12'd0) begin
      errors++; $display("FAIL flush_block: valid=%b tag=%h expected 00/000", fl.alloc_valid, fl.alloc_tag);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl.free_count !== 7'd4) begin
      errors++; $display("FAIL flush_count: got %0d expected 4", fl.free_count);
    end
    fl.alloc_req = 2'b11;
    #1;
    checks++;
    if (fl.alloc_valid !== 2'b11 || fl.alloc_tag !== {6'd20, 6'd7}) begin
      errors++; $display("FAIL flush_offer: valid=%b tag=%h expected 11/%h", fl.alloc_valid, fl.alloc_tag, {6'd20, 6'd7});
    end
    fl.alloc_req = 2'b00;
  endtask

  task automatic test_double_free;
    fl.retire_valid = 2'b11;
    fl.retire_told  = {6'd50, 6'd50};
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl.free_count !== 7'd5 || fl.err_double_free !== 1'b1) begin
      errors++; $display("FAIL dbl_same_cycle: count=%0d err=%b expected 5/1", fl.free_count, fl.err_double_free);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (fl.free_count !== 7'd32 || fl.err_double_free !== 1'b0) begin
      errors++; $display("FAIL async_reset1: count=%0d err=%b expected 32/0", fl.free_count, fl.err_double_free);
    end
    reset = 1'b0;
    #1;
    fl.alloc_req = 2'b11;
    #1;
    checks++;
    if (fl.alloc_tag !== {6'd33, 6'd32}) begin
      errors++; $display("FAIL async_reset_offer: tag=%h expected %h", fl.alloc_tag, {6'd33, 6'd32});
    end
    fl.alloc_req    = 2'b00;
    fl.retire_valid = 2'b01;
    fl.retire_told  = {6'd0, 6'd33};
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl.free_count !== 7'd32 || fl.err_double_free !== 1'b1) begin
      errors++; $display("FAIL dbl_free: count=%0d err=%b expected 32/1", fl.free_count, fl.err_double_free);
    end
    tick();
    #1;
    checks++;
    if (fl.err_double_free !== 1'b1) begin
      errors++; $display("FAIL dbl_sticky: err=%b expected 1", fl.err_double_free);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (fl.free_count !== 7'd32 || fl.err_double_free !== 1'b0) begin
      errors++; $display("FAIL async_reset2: count=%0d err=%b expected 32/0", fl.free_count, fl.err_double_free);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc();
    test_retire();
    test_drain();
    test_lane_gap();
    test_flush();
    test_double_free();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
